// File: rtl/quant_div_pkg.sv
// -----------------------------------------------------------------------------
// quant_div_pkg
// Shared definitions for the quantization-stage divider:
//   - div_state_e : FSM state encoding (IDLE, DIVIDE, FINISH)
//   - cnt_width() : iteration counter width, $clog2(WIDTH+1)
//   - sat_pos()/sat_neg() : divide-by-zero saturation limits for a given WIDTH
//     (returned as 32-bit patterns, callers keep the low WIDTH bits)
// -----------------------------------------------------------------------------
package quant_div_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FINISH = 2'd2
  } div_state_e;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Largest positive value: 2^(width-1)-1
  function automatic logic [31:0] sat_pos(input int width);
    return (32'd1 << (width - 1)) - 32'd1;
  endfunction

  // Most negative value -2^(width-1) as a two's-complement bit pattern
  function automatic logic [31:0] sat_neg(input int width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/udiv_core.sv
// -----------------------------------------------------------------------------
// udiv_core
// Unsigned restoring division datapath, one quotient bit per step, MSB first.
// The dividend magnitude is loaded into the quotient register and shifted out
// of its MSB while quotient bits are shifted in at the LSB.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   i_load           capture operands, clear partial remainder and counter
//   i_step           perform one shift/trial-subtract iteration
//   i_dividend_mag   unsigned dividend magnitude (WIDTH)
//   i_divisor        unsigned divisor (WIDTH)
//   o_last           high while the counter points at the final iteration
//   o_quo_mag        unsigned quotient (valid after WIDTH steps)
//   o_rem_mag        unsigned remainder (valid after WIDTH steps)
//   o_divisor        captured divisor
// -----------------------------------------------------------------------------
module udiv_core
  import quant_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_dividend_mag,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_last,
  output logic [WIDTH-1:0] o_quo_mag,
  output logic [WIDTH-1:0] o_rem_mag,
  output logic [WIDTH-1:0] o_divisor
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_prem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [CW-1:0]    r_cnt;

  // The kept partial remainder is always < divisor, so it fits in WIDTH bits;
  // the WIDTH+1-bit quantity is the shifted trial value. One extra bit on the
  // difference gives the borrow that decides keep vs. restore.
  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_ge;

  assign w_shift = {r_prem, r_quo[WIDTH-1]};
  assign w_diff  = {1'b0, w_shift} - {2'b00, r_div};
  assign w_ge    = ~w_diff[WIDTH+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prem <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_prem <= '0;
      r_quo  <= i_dividend_mag;
      r_div  <= i_divisor;
      r_cnt  <= '0;
    end else if (i_step) begin
      r_prem <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
      r_quo  <= {r_quo[WIDTH-2:0], w_ge};
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  assign o_last    = (r_cnt == LAST_CNT);
  assign o_quo_mag = r_quo;
  assign o_rem_mag = r_prem;
  assign o_divisor = r_div;

endmodule

// File: rtl/quant_divider.sv
// -----------------------------------------------------------------------------
// quant_divider
// Iterative signed-by-unsigned divider for the quantization stage
// (DCT coefficient / quantization-table entry). One division in flight,
// fixed latency: done pulses in the cycle after the (WIDTH+1)th edge
// following the accept edge, including divide-by-zero.
//
// Handshake: start is sampled only while busy=0 (FSM IDLE). Operands need
// only be valid at that accept edge. A start in the done cycle is accepted.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         division request
//   dividend      two's-complement dividend (WIDTH)
//   divisor       unsigned divisor (WIDTH)
//   busy          division in progress
//   done          one-cycle result strobe
//   quotient      signed quotient, truncated toward zero (held until next done)
//   remainder     signed remainder, sign of dividend (held until next done)
//   div_by_zero   captured divisor was zero (held until next done)
//   dbg_state     current FSM state (div_state_e encoding)
//
// Build option: define ROUND_NEAREST_EN to round the quotient half away from
// zero (remainder still reports the truncated-division remainder).
// -----------------------------------------------------------------------------
module quant_divider
  import quant_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);

  localparam logic [31:0]      SAT_POS_32 = sat_pos(WIDTH);
  localparam logic [31:0]      SAT_NEG_32 = sat_neg(WIDTH);
  localparam logic [WIDTH-1:0] SAT_POS    = SAT_POS_32[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SAT_NEG    = SAT_NEG_32[WIDTH-1:0];

  div_state_e       r_state;
  div_state_e       w_next;
  logic             w_load;
  logic             w_step;
  logic             w_finish;

  logic             r_neg;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dz;

  logic             w_last;
  logic [WIDTH-1:0] w_dividend_mag;
  logic [WIDTH-1:0] w_quo_mag;
  logic [WIDTH-1:0] w_rem_mag;
  logic [WIDTH-1:0] w_div_q;
  logic [WIDTH-1:0] w_qmag_fin;
  logic             w_dz;

  // Negating -2^(WIDTH-1) yields the same bit pattern, which read as unsigned
  // is exactly its magnitude 2^(WIDTH-1).
  assign w_dividend_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;

  udiv_core #(.WIDTH(WIDTH)) u_core (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_load         (w_load),
    .i_step         (w_step),
    .i_dividend_mag (w_dividend_mag),
    .i_divisor      (divisor),
    .o_last         (w_last),
    .o_quo_mag      (w_quo_mag),
    .o_rem_mag      (w_rem_mag),
    .o_divisor      (w_div_q)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_step   = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = DIVIDE;
        end
      end
      DIVIDE: begin
        w_step = 1'b1;
        if (w_last) w_next = FINISH;
      end
      FINISH: begin
        w_finish = 1'b1;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sign, rounding and result registers
  // ---------------------------------------------------------------------------
  assign w_dz = (w_div_q == '0);

`ifdef ROUND_NEAREST_EN
  // Round half away from zero on the magnitude; |q|+1 cannot overflow because
  // a nonzero remainder needs divisor >= 2, which caps |q| at 2^(WIDTH-2).
  logic [WIDTH:0] w_rem_x2;
  logic           w_round_up;
  assign w_rem_x2   = {w_rem_mag, 1'b0};
  assign w_round_up = (w_rem_x2 >= {1'b0, w_div_q});
  assign w_qmag_fin = w_quo_mag + {{(WIDTH-1){1'b0}}, w_round_up};
`else
  assign w_qmag_fin = w_quo_mag;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg  <= 1'b0;
      r_done <= 1'b0;
      r_quot <= '0;
      r_rem  <= '0;
      r_dz   <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_load) r_neg <= dividend[WIDTH-1];
      if (w_finish) begin
        r_dz <= w_dz;
        if (w_dz) begin
          r_quot <= r_neg ? SAT_NEG : SAT_POS;
          r_rem  <= '0;
        end else begin
          r_quot <= r_neg ? (~w_qmag_fin + 1'b1) : w_qmag_fin;
          r_rem  <= r_neg ? (~w_rem_mag + 1'b1) : w_rem_mag;
        end
      end
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dz;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_quant_divider.sv
// -----------------------------------------------------------------------------
// tb_quant_divider
// Scoreboard bench: an accept watcher pushes the reference result of every
// accepted request into exp_q; a monitor pops and compares on each done.
// -----------------------------------------------------------------------------
module tb_quant_divider;

  localparam int W   = 16;
  localparam int LAT = W + 1;
  localparam int EW  = 32 + 1 + 2 * W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic [1:0]   dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int cyc     = 0;

  logic [EW-1:0] exp_q[$];
  int            done_cyc_q[$];

  quant_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock / cycle counter / watchdog
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (tests=%0d)", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: plain integer division semantics
  // Returns {div_by_zero, quotient, remainder}
  // ---------------------------------------------------------------------------
  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, ub, q, r, ar;
    logic   dz;
    sa = $signed(a);
    ub = b;
    dz = 1'b0;
    if (ub == 0) begin
      dz = 1'b1;
      q  = (sa >= 0) ? ((longint'(1) << (W - 1)) - 1) : -(longint'(1) << (W - 1));
      r  = 0;
    end else begin
      q = sa / ub;
      r = sa % ub;
`ifdef ROUND_NEAREST_EN
      ar = (r < 0) ? -r : r;
      if (2 * ar >= ub) q = (sa < 0) ? q - 1 : q + 1;
`else
      ar = 0;
`endif
    end
    return {dz, q[W-1:0], r[W-1:0]};
  endfunction

  // ---------------------------------------------------------------------------
  // Accept watcher: a request is accepted on an edge where start=1, busy=0
  // ---------------------------------------------------------------------------
  always @(posedge clk) begin
    if (rst_n && start && !busy)
      exp_q.push_back({32'(cyc + 1), model(dividend, divisor)});
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  initial begin : monitor
    logic          prev_done;
    logic [EW-1:0] e;
    int            acc;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (done && prev_done) check("done_twice", 1, 0);
        if (done) begin
          n_done++;
          done_cyc_q.push_back(cyc);
          if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e   = exp_q.pop_front();
            acc = int'(e[EW-1 -: 32]);
            check("quotient",    quotient,    e[2*W-1:W]);
            check("remainder",   remainder,   e[W-1:0]);
            check("div_by_zero", div_by_zero, e[2*W]);
            check("latency",     cyc - acc,   LAT);
          end
        end
        prev_done = done;
      end else begin
        prev_done = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (busy) check("drv_idle_timeout", 1, 0);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || busy) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [W-1:0] dir_a[18];
  logic [W-1:0] dir_b[18];

  initial begin : stim
    int nd0;
    int bad;
    logic [W-1:0] ra, rb;

    dir_a = '{16'd100, -16'sd100, 16'd100, -16'sd100, 16'd99, 16'd5,
              16'h8000, 16'd32767, 16'h8000, 16'd5, -16'sd5, 16'd6,
              16'h7FFF, 16'hFFFF, 16'd0, 16'h8000, 16'd1234, -16'sd1234};
    dir_b = '{16'd7, 16'd7, 16'd8, 16'd8, 16'd8, 16'd10,
              16'd1, 16'd65535, 16'd40000, 16'd0, 16'd0, 16'd3,
              16'd1, 16'd2, 16'd9, 16'd3, 16'd65535, 16'd2};

    // Reset state
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_state", dbg_state, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 100/7: busy throughout, done after 17 edges
    do_div(16'd100, 16'd7);
    bad = 0;
    for (int i = 0; i <= W; i++) begin
      if (!busy) bad++;
      @(negedge clk);
    end
    check("busy_during_div", bad, 0);
    check("done_at_lat", done, 1);
    check("busy_at_done", busy, 0);
    drain();

    // Directed table
    for (int i = 0; i < 18; i++) do_div(dir_a[i], dir_b[i]);
    drain();

    // start pulses at cycles 3 and 9 after accept are ignored
    nd0 = n_done;
    do_div(16'd500, 16'd3);
    repeat (2) @(negedge clk);
    dividend = 16'd77; divisor = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    dividend = -16'sd9; divisor = 16'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    check("ignored_start_done_count", n_done - nd0, 1);

    // start held high: back-to-back accepts, done every 18 cycles
    done_cyc_q.delete();
    dividend = -16'sd3000; divisor = 16'd11; start = 1'b1;
    repeat (3 * (LAT + 1) + 2) @(negedge clk);
    start = 1'b0;
    drain();
    check("held_start_dones_ge3", done_cyc_q.size() >= 3, 1);
    for (int i = 1; i < done_cyc_q.size(); i++)
      check("held_start_spacing", done_cyc_q[i] - done_cyc_q[i-1], LAT + 1);

    // Reset mid-operation aborts with outputs cleared
    do_div(16'd12345, 16'd7);
    drain();
    do_div(-16'sd20000, 16'd13);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("abort_busy", busy, 0);
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_dbz", div_by_zero, 0);
    check("abort_state", dbg_state, 0);
    nd0 = n_done;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_done", n_done - nd0, 0);

    // Randomized operands
    for (int i = 0; i < 120; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 16));
        2:       rb = W'($urandom_range(1, 300));
        default: rb = W'($urandom);
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_div(ra, rb);
    end
    drain();

    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
